// File: rtl/gyr_light_monitor_if.sv
// Lamp, error-clear and status bundle between the traffic-light generator side and gyr_light_monitor.
// When GYR_MON_ONEHOT_CHK_EN is defined the bundle also carries the err_overlap flag.
interface gyr_light_monitor_if #(
  parameter int CNT_W = 8
);
  logic             green;
  logic             yellow;
  logic             red;
  logic             err_clr;
  logic [1:0]       cur_phase;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] last_dwell;
  logic [CNT_W-1:0] cycle_cnt;
  logic             err_order;
  logic             err_dark;
  logic             err_all;
  logic             err_stuck;
  logic [1:0]       state_dbg;
`ifdef GYR_MON_ONEHOT_CHK_EN
  logic             err_overlap;
`endif

  // Level signals sampled every clock. There is no valid/ready pair:
  // every edge is a transaction, and every output is registered.
  modport master (
    output green, yellow, red, err_clr,
    input  cur_phase, dwell, last_dwell, cycle_cnt,
    input  err_order, err_dark, err_all, err_stuck, state_dbg
`ifdef GYR_MON_ONEHOT_CHK_EN
    , input err_overlap
`endif
  );

  modport slave (
    input  green, yellow, red, err_clr,
    output cur_phase, dwell, last_dwell, cycle_cnt,
    output err_order, err_dark, err_all, err_stuck, state_dbg
`ifdef GYR_MON_ONEHOT_CHK_EN
    , output err_overlap
`endif
  );
endinterface

// File: rtl/gyr_light_monitor.sv
// Observes G/Y/R lamps, tracks the G->Y->R->G rising-edge order, counts cycles, measures dwell, and keeps sticky error flags.
// Defining GYR_MON_ONEHOT_CHK_EN adds the sticky err_overlap check, which flags two or more lamps lit while tracking.
module gyr_light_monitor #(
  parameter int CNT_W    = 8,
  parameter int MAX_IDLE = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  gyr_light_monitor_if.slave   mon
);

  typedef enum logic [1:0] {
    S_WAIT_G = 2'd0,
    S_EXP_Y  = 2'd1,
    S_EXP_R  = 2'd2,
    S_EXP_G  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_g_q, prev_y_q, prev_r_q;
  logic             err_order_q, err_order_d;
  logic             err_dark_q, err_dark_d;
  logic             err_all_q, err_all_d;
  logic             err_stuck_q, err_stuck_d;
  logic             rise_g, rise_y, rise_r;
  logic [1:0]       n_rise;
  logic [1:0]       n_on;
  logic             tracking;
  logic             order_set;
`ifdef GYR_MON_ONEHOT_CHK_EN
  logic             err_overlap_q, err_overlap_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    rise_g    = mon.green  & ~prev_g_q;
    rise_y    = mon.yellow & ~prev_y_q;
    rise_r    = mon.red    & ~prev_r_q;
    n_rise    = 2'(rise_g) + 2'(rise_y) + 2'(rise_r);
    n_on      = 2'(mon.green) + 2'(mon.yellow) + 2'(mon.red);
    tracking  = (state_q != S_WAIT_G);
    state_d   = state_q;
    phase_d   = phase_q;
    dwell_d   = dwell_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    order_set = 1'b0;

    if (n_rise >= 2'd2) begin
      // Simultaneous rises leave the order ambiguous, so drop back and resync on green.
      order_set = 1'b1;
      state_d   = S_WAIT_G;
      phase_d   = 2'd0;
      if (tracking) begin
        dwell_d = '0;
        last_d  = sat_inc(dwell_q);
      end
    end else if (!tracking) begin
      dwell_d = '0;
      if (rise_g) begin
        state_d = S_EXP_Y;
        phase_d = 2'd1;
        last_d  = sat_inc(dwell_q);
      end
    end else if (n_rise == 2'd1) begin
      dwell_d = '0;
      last_d  = sat_inc(dwell_q);
      if (rise_g) begin
        state_d = S_EXP_Y;
        phase_d = 2'd1;
        if (state_q == S_EXP_G) cnt_d = cnt_q + 1'b1;
        else                    order_set = 1'b1;
      end else if (rise_y) begin
        state_d   = S_EXP_R;
        phase_d   = 2'd2;
        order_set = (state_q != S_EXP_Y);
      end else begin
        state_d   = S_EXP_G;
        phase_d   = 2'd3;
        order_set = (state_q != S_EXP_R);
      end
    end else begin
      dwell_d = sat_inc(dwell_q);
    end

    // Sticky flags: a set condition overrides a simultaneous clear.
    err_order_d = order_set | (err_order_q & ~mon.err_clr);
    err_dark_d  = (tracking & ~(mon.green | mon.yellow | mon.red))
                | (err_dark_q & ~mon.err_clr);
    err_all_d   = (mon.green & mon.yellow & mon.red) | (err_all_q & ~mon.err_clr);
    err_stuck_d = (tracking & (dwell_q == CNT_W'(MAX_IDLE)))
                | (err_stuck_q & ~mon.err_clr);
`ifdef GYR_MON_ONEHOT_CHK_EN
    err_overlap_d = (tracking & (n_on >= 2'd2)) | (err_overlap_q & ~mon.err_clr);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_WAIT_G;
      phase_q     <= '0;
      dwell_q     <= '0;
      last_q      <= '0;
      cnt_q       <= '0;
      prev_g_q    <= 1'b0;
      prev_y_q    <= 1'b0;
      prev_r_q    <= 1'b0;
      err_order_q <= 1'b0;
      err_dark_q  <= 1'b0;
      err_all_q   <= 1'b0;
      err_stuck_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      prev_g_q    <= mon.green;
      prev_y_q    <= mon.yellow;
      prev_r_q    <= mon.red;
      err_order_q <= err_order_d;
      err_dark_q  <= err_dark_d;
      err_all_q   <= err_all_d;
      err_stuck_q <= err_stuck_d;
    end
  end

`ifdef GYR_MON_ONEHOT_CHK_EN
  always_ff @(posedge clk) begin
    if (!rstn) err_overlap_q <= 1'b0;
    else       err_overlap_q <= err_overlap_d;
  end
  assign mon.err_overlap = err_overlap_q;
`else
  // Lamp-overlap counting is only meaningful with the one-hot check.
  logic unused_n_on;
  assign unused_n_on = ^n_on;
`endif

  assign mon.cur_phase  = phase_q;
  assign mon.dwell      = dwell_q;
  assign mon.last_dwell = last_q;
  assign mon.cycle_cnt  = cnt_q;
  assign mon.err_order  = err_order_q;
  assign mon.err_dark   = err_dark_q;
  assign mon.err_all    = err_all_q;
  assign mon.err_stuck  = err_stuck_q;
  assign mon.state_dbg  = state_q;

endmodule

// File: tb/tb_gyr_light_monitor.sv
// Directed-vector bench for gyr_light_monitor: the driver queues hand-computed expectations per cycle,
// and an independent monitor pops them and compares after every active edge.
module tb_gyr_light_monitor;
  localparam int CNT_W = 8;
  localparam int EXP_W = 31;
  localparam logic [4:0] OV  = 5'b00001;
  localparam logic [4:0] STK = 5'b00010;

  // err bits: {order, dark, all, stuck, overlap}
  typedef struct packed {
    logic [1:0] ph;
    logic [7:0] dw;
    logic [7:0] ld;
    logic [7:0] cc;
    logic [4:0] err;
  } exp_t;

  logic clk;
  logic rstn;
  logic [EXP_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  gyr_light_monitor_if #(.CNT_W(CNT_W)) mon_if();

  gyr_light_monitor #(.CNT_W(CNT_W), .MAX_IDLE(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .mon  (mon_if)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL cycle %0d %s: got %0d expected %0d", n_cyc, name, act, exp_v);
    end
  endtask

  // Driver: inputs change on the falling edge, expectation is queued for the next rising edge.
  // cur_phase and the state encoding coincide (0 wait, 1 exp Y, 2 exp R, 3 exp G), so ph covers both.
  task automatic cyc(input logic rst_n, input logic [2:0] gyr, input logic clr,
                     input logic [1:0] ph, input logic [7:0] dw, input logic [7:0] ld,
                     input logic [7:0] cc, input logic [4:0] err);
    exp_t e;
    @(negedge clk);
    rstn           = rst_n;
    mon_if.green   = gyr[2];
    mon_if.yellow  = gyr[1];
    mon_if.red     = gyr[0];
    mon_if.err_clr = clr;
    e.ph = ph; e.dw = dw; e.ld = ld; e.cc = cc; e.err = err;
    exp_q.push_back(e);
  endtask

  // Monitor: checks every registered output one step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cur_phase",  int'(mon_if.cur_phase),  int'(e.ph));
        chk("state",      int'(mon_if.state_dbg),  int'(e.ph));
        chk("dwell",      int'(mon_if.dwell),      int'(e.dw));
        chk("last_dwell", int'(mon_if.last_dwell), int'(e.ld));
        chk("cycle_cnt",  int'(mon_if.cycle_cnt),  int'(e.cc));
        chk("err_order",  int'(mon_if.err_order),  int'(e.err[4]));
        chk("err_dark",   int'(mon_if.err_dark),   int'(e.err[3]));
        chk("err_all",    int'(mon_if.err_all),    int'(e.err[2]));
        chk("err_stuck",  int'(mon_if.err_stuck),  int'(e.err[1]));
`ifdef GYR_MON_ONEHOT_CHK_EN
        chk("err_overlap", int'(mon_if.err_overlap), int'(e.err[0]));
`endif
        n_cyc++;
      end
    end
  end

  initial begin
    rstn = 1'b0;
    mon_if.green = 1'b0; mon_if.yellow = 1'b0; mon_if.red = 1'b0; mon_if.err_clr = 1'b0;

    // Reset state, then one idle cycle in the wait state
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 5'b0);
    cyc(0, 3'b000, 0, 0, 0, 0, 0, 5'b0);
    cyc(1, 3'b000, 0, 0, 0, 0, 0, 5'b0);

    // Normal sequence with overlapping lamps, two full cycles
    cyc(1, 3'b100, 0, 1, 0, 1, 0, 5'b0);
    cyc(1, 3'b110, 0, 2, 0, 1, 0, OV);
    cyc(1, 3'b010, 0, 2, 1, 1, 0, OV);
    cyc(1, 3'b011, 0, 3, 0, 2, 0, OV);
    cyc(1, 3'b101, 0, 1, 0, 1, 1, OV);
    cyc(1, 3'b110, 0, 2, 0, 1, 1, OV);
    cyc(1, 3'b010, 0, 2, 1, 1, 1, OV);
    cyc(1, 3'b011, 0, 3, 0, 2, 1, OV);
    cyc(1, 3'b101, 0, 1, 0, 1, 2, OV);

    // Out-of-order green while expecting red, then clear
    cyc(1, 3'b010, 0, 2, 0, 1, 2, OV);
    cyc(1, 3'b100, 0, 1, 0, 1, 2, 5'b10001);
    cyc(1, 3'b100, 1, 1, 1, 1, 2, 5'b0);

    // Stall: yellow held, stuck flag after dwell passes MAX_IDLE, then clear
    cyc(1, 3'b010, 0, 2, 0, 2, 2, 5'b0);
    for (int i = 1; i <= 19; i++)
      cyc(1, 3'b010, 0, 2, 8'(i), 2, 2, (i >= 17) ? STK : 5'b0);
    cyc(1, 3'b010, 1, 2, 20, 2, 2, 5'b0);

    // All dark, then all on with simultaneous rises
    cyc(1, 3'b000, 0, 2, 21, 2, 2, 5'b01000);
    cyc(1, 3'b111, 0, 0, 0, 22, 2, 5'b11101);

    // Clear coinciding with all-on (set wins), then mid-run reset
    cyc(1, 3'b111, 1, 0, 0, 22, 2, 5'b00100);
    cyc(0, 3'b111, 0, 0, 0, 0, 0, 5'b0);
    cyc(1, 3'b000, 0, 0, 0, 0, 0, 5'b0);

    // Fresh tracking after reset, cycle count restarts at 0
    cyc(1, 3'b100, 0, 1, 0, 1, 0, 5'b0);
    cyc(1, 3'b110, 0, 2, 0, 1, 0, OV);
    cyc(1, 3'b010, 0, 2, 1, 1, 0, OV);
    cyc(1, 3'b011, 0, 3, 0, 2, 0, OV);
    cyc(1, 3'b101, 0, 1, 0, 1, 1, OV);

    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
